jk_mod_counter: RTL
===================

# jk_mod_counter

Synchronous modulo-MOD up/down counter whose state register is a bank of WIDTH JK flip-flops, plus the excitation logic that computes each flip-flop's J/K inputs from the desired next state. It is the driving end of the JK storage element: the JK flip-flop block turns J/K into state, and this block turns the desired state sequence into J/K. It sits in the lab counter/sequencer datapath and feeds display decoders and cascaded counter stages through TC/CO.

## Interface
- WIDTH, 4, number of JK flip-flops; must satisfy 2^WIDTH >= MOD
- MOD, 10, count modulus; legal range 2..2^WIDTH
- Cp  input  1  clock; all state changes on rising edge
- CLR  input  1  reset, asynchronous, active-high; forces state to 0 immediately
- EN  input  1  count enable
- UP  input  1  direction: 1 = up, 0 = down
- LD  input  1  synchronous parallel load; overrides EN
- D  input  WIDTH  load value
- Q  output  WIDTH  counter state (the flip-flop outputs)
- Qbar  output  WIDTH  bitwise complement of Q, always
- J  output  WIDTH  excitation presented to the flip-flop bank this cycle
- K  output  WIDTH  excitation presented to the flip-flop bank this cycle
- TC  output  1  terminal count, combinational
- CO  output  1  registered carry/borrow pulse

## Operation
- Next-state value N, priority order:
  - LD=1: N = D (any value, including D >= MOD).
  - LD=0, EN=1, UP=1: N = 0 if Q >= MOD-1, else Q+1.
  - LD=0, EN=1, UP=0: N = MOD-1 if Q == 0 or Q >= MOD, else Q-1.
  - LD=0, EN=0: N = Q.
- Excitation per bit i (minimal toggle-free form):
  - J[i] = N[i] & ~Q[i]
  - K[i] = ~N[i] & Q[i]
  - Bits that hold: J=K=0. J=K=1 is never produced.
- Flip-flop update per bit on rising Cp: Q[i] <= (J[i] & ~Q[i]) | (~K[i] & Q[i]). Register only via this JK equation, never by direct assignment of N.
- TC = EN & ~LD & ((UP & Q == MOD-1) | (~UP & Q == 0)).
- CO: on each edge, CO <= TC. A one-cycle pulse in the cycle after a wrap (MOD-1→0 up, 0→MOD-1 down).
- Illegal states (Q >= MOD, only reachable via load): the next up count goes to 0, the next down count goes to MOD-1. TC is 0 in an illegal state and CO does not pulse on that recovery.
- All arithmetic is WIDTH bits unsigned. Comparisons are against MOD-1 sized to WIDTH.

## Timing
- CLR=1: Q=0, Qbar=all ones, CO=0, asynchronously (no edge needed). J/K/TC follow combinationally from Q=0.
- CLR deasserted: the first rising Cp with CLR=0 performs the first update. Releasing CLR coincident with an edge is a bench no-go; the behaviour is unspecified.
- CLR asserted mid-count or mid-load discards that cycle's operation. No pending state survives.
- Latency: Q reflects N one cycle after the inputs are sampled. CO lags TC by one cycle.
- J, K, and TC are combinational from Q, D, EN, UP, LD, and are valid before each rising edge.
- Simultaneous LD=1 and EN=1: load wins, TC=0, and no CO is produced.
- UP may change every cycle. A direction change takes effect on the same edge.

## Test plan
- Reset: hold CLR=1 and toggle Cp → Q=0, Qbar=4'hF, CO=0. Assert CLR between edges with Q=7 → Q=0 immediately.
- Up wrap, MOD=10: EN=1, UP=1 for 12 cycles from 0 → Q = 1..9, 0, 1, 2. TC=1 only while Q=9. CO=1 exactly one cycle, while Q=0.
- Excitation check: Q=7 going up to 8 → J=4'b1000, K=4'b0111. Q=9 going up to 0 → J=0, K=4'b1001. EN=0 → J=K=0 and Q holds.
- Down wrap: load D=0, then EN=1, UP=0 → Q = 9, 8, 7. TC=1 in the Q=0 cycle. CO pulses in the Q=9 cycle.
- Load priority and illegal state: LD=1, EN=1, D=13 → Q=13, TC=0, CO=0. Next edge with UP=1 → Q=0 and no CO. Repeat with UP=0 → Q=9.
- Parameter sweep: WIDTH=3, MOD=8 and WIDTH=4, MOD=16 → a full natural binary wrap both directions. Assert that J&K is never nonzero in any cycle.

Source files
------------

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built on a bank of JK flip-flops.
// The excitation logic turns the desired next state into per-bit J/K,
// and the state register only ever updates through the JK equation.
module jk_mod_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 10
) (
  input  logic             Cp,
  input  logic             CLR,
  input  logic             EN,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             TC,
  output logic             CO
);

  // Largest legal count, sized to the register width.
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] nxt;
  logic             illegal;

  // Desired next state: load beats count, and count beats hold.
  // Illegal states (above TOP) recover to 0 going up and to TOP going down.
  always_comb begin
    nxt     = Q;
    illegal = (Q > TOP);
    if (LD) begin
      nxt = D;
    end else if (EN) begin
      if (UP) begin
        nxt = (Q >= TOP) ? '0 : Q + WIDTH'(1);
      end else begin
        nxt = ((Q == '0) || illegal) ? TOP : Q - WIDTH'(1);
      end
    end
  end

  // Minimal excitation: set bits that rise, reset bits that fall, never toggle.
  always_comb begin
    J = nxt & ~Q;
    K = ~nxt & Q;
  end

  // Terminal count is only flagged for a real wrap; illegal states never match.
  always_comb begin
    TC = EN & ~LD & ((UP & (Q == TOP)) | (~UP & (Q == '0)));
  end

  // Complementary flip-flop output.
  always_comb begin
    Qbar = ~Q;
  end

  // JK flip-flop bank plus the registered carry/borrow pulse.
  always_ff @(posedge Cp or posedge CLR) begin
    if (CLR) begin
      Q  <= '0;
      CO <= 1'b0;
    end else begin
      Q  <= (J & ~Q) | (~K & Q);
      CO <= TC;
    end
  end

endmodule
